// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: credit-limited requests to a fixed-latency
// instruction memory, a small response FIFO, and a valid/ready decode port.
module inst_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          LAT      = 2,
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  output logic        inst_req,
  output logic [11:0] inst_addr,
  input  logic [31:0] inst_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [11:0] dec_pc,
  input  logic        dec_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 1);

  logic [11:0]   pc_reg;
  logic [LAT-1:0] pipe_valid_reg;
  logic [11:0]   pipe_pc_reg [LAT];
  logic [43:0]   fifo_mem_reg [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] fifo_cnt_reg;
  logic [CW-1:0] inflight_cnt;
  logic          issue;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_cnt = inflight_cnt + CW'(pipe_valid_reg[i]);
    end
  end

  // A redirect flushes every outstanding slot, so its request never waits for credit.
  assign issue     = rst_n & fetch_en &
                     (redirect | ((inflight_cnt + fifo_cnt_reg) < CW'(DEPTH)));
  assign inst_req  = issue;
  assign inst_addr = redirect ? redirect_pc : pc_reg;

  assign dec_valid          = (fifo_cnt_reg != '0) & ~redirect;
  assign {dec_pc, dec_inst} = fifo_mem_reg[rd_ptr_reg];

  assign push = pipe_valid_reg[LAT-1] & ~redirect;
  assign pop  = dec_valid & dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (redirect) begin
      pc_reg <= redirect_pc + 12'(issue);
    end else if (issue) begin
      pc_reg <= pc_reg + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_valid_reg[i] <= 1'b0;
        pipe_pc_reg[i]    <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= issue;
      pipe_pc_reg[0]    <= inst_addr;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1] & ~redirect;
        pipe_pc_reg[i]    <= pipe_pc_reg[i-1];
      end
    end
  end

  // Entries are cleared on reset so dec_inst/dec_pc read as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_reg[i] <= '0;
      end
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else if (redirect) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) begin
        fifo_mem_reg[wr_ptr_reg] <= {pipe_pc_reg[LAT-1], inst_rdata};
        wr_ptr_reg               <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed scenarios then random traffic, checked
// against a queue model of issued-but-unconsumed requests.
module tb_inst_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        inst_req;
  logic [11:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [11:0] dec_pc;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .LAT(LAT), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  function automatic logic [31:0] word(input logic [11:0] a);
    return 32'h1000_0000 + {20'd0, a};
  endfunction

  // Instruction memory: registered SRAM read followed by one output register.
  logic [31:0] mem_q1 = 32'hDEAD_BEEF;
  logic [31:0] mem_q2 = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    mem_q1 <= inst_req ? word(inst_addr) : 32'hDEAD_BEEF;
    mem_q2 <= mem_q1;
  end
  assign inst_rdata = mem_q2;

  typedef struct {
    logic [11:0] pc;
    int          t;
  } req_t;

  req_t        q[$];
  int          cyc = 0;
  logic [11:0] pc_m = 12'h000;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fe, input logic rd, input logic rdr, input logic [11:0] rpc);
    logic exp_issue;
    logic exp_valid;
    @(negedge clk);
    fetch_en    = fe;
    dec_ready   = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
    exp_issue = fe && (rdr || q.size() < DEPTH);
    exp_valid = !rdr && q.size() > 0 && (cyc - q[0].t >= LAT + 1);
    chk("inst_req", {31'd0, inst_req}, {31'd0, exp_issue});
    chk("inst_addr", {20'd0, inst_addr}, {20'd0, (rdr ? rpc : pc_m)});
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("dec_pc", {20'd0, dec_pc}, {20'd0, q[0].pc});
      chk("dec_inst", dec_inst, word(q[0].pc));
    end
    if (exp_valid && rd) begin
      $display("cyc %0d: deliver pc=%h inst=%h", cyc, dec_pc, dec_inst);
    end
    if (rdr) begin
      q.delete();
      if (exp_issue) q.push_back('{pc: rpc, t: cyc});
      pc_m = rpc + 12'(exp_issue);
    end else begin
      if (exp_valid && rd) void'(q.pop_front());
      if (exp_issue) begin
        q.push_back('{pc: pc_m, t: cyc});
        pc_m = pc_m + 12'd1;
      end
    end
    cyc++;
  endtask

  initial begin
    logic        fe;
    logic        rd;
    logic        rdr;
    logic [11:0] rpc;

    #12;
    chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_dec_inst", dec_inst, 32'd0);
    chk("rst_dec_pc", {20'd0, dec_pc}, 32'd0);
    chk("rst_inst_addr", {20'd0, inst_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming
    repeat (12) step(1'b1, 1'b1, 1'b0, 12'h0);
    // backpressure then release
    repeat (8) step(1'b1, 1'b0, 1'b0, 12'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 12'h0);
    // redirect with requests in flight
    step(1'b1, 1'b1, 1'b1, 12'h100);
    repeat (6) step(1'b1, 1'b1, 1'b0, 12'h0);
    // wrap-around
    step(1'b1, 1'b1, 1'b1, 12'hFFE);
    repeat (8) step(1'b1, 1'b1, 1'b0, 12'h0);
    // fetch_en dropped
    repeat (5) step(1'b0, 1'b1, 1'b0, 12'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 12'h0);
    // fill the FIFO, then asynchronous reset mid-cycle
    repeat (4) step(1'b1, 1'b0, 1'b0, 12'h0);
    @(negedge clk);
    fetch_en  = 1'b1;
    dec_ready = 1'b0;
    redirect  = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("async_rst_inst_req", {31'd0, inst_req}, 32'd0);
    chk("async_rst_dec_pc", {20'd0, dec_pc}, 32'd0);
    chk("async_rst_dec_inst", dec_inst, 32'd0);
    q.delete();
    pc_m = 12'h000;
    cyc++;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) step(1'b1, 1'b1, 1'b0, 12'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      fe  = ($urandom_range(0, 9) != 0);
      rd  = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? 12'($urandom) : 12'hFFC + 12'($urandom_range(0, 3));
      step(fe, rd, rdr, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
